// File: rtl/icache_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// slave is the cache's view; master is the fetch unit / refill controller view.
interface icache_if #(
    parameter int XLEN = 32
);
    logic            fetch_req;
    logic [XLEN-1:0] fetch_addr;
    logic            flush;
    logic            fetch_valid;
    logic [XLEN-1:0] fetch_data;
    logic            stall;
    logic            cache_miss;
    logic [XLEN-1:0] miss_addr;
    logic            refill_valid;
    logic [XLEN-1:0] refill_data;
    logic            refill_done;

    modport slave (
        input  fetch_req, fetch_addr, flush, refill_valid, refill_data, refill_done,
        output fetch_valid, fetch_data, stall, cache_miss, miss_addr
    );

    modport master (
        output fetch_req, fetch_addr, flush, refill_valid, refill_data, refill_done,
        input  fetch_valid, fetch_data, stall, cache_miss, miss_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, 4-word lines, single outstanding miss.
// state  | meaning
// IDLE   | lookups accepted, 1-cycle hit latency
// MISS   | one-cycle cache_miss pulse to the refill controller
// REFILL | capturing line words in order from the line base
// REPLAY | returning the missed word, then back to IDLE
module icache #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4,
    parameter int XLEN       = 32
) (
    input  logic  clk,
    input  logic  reset,
    icache_if.slave bus
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = XLEN - IDX_W - OFF_W - 2;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, MISS, REFILL, REPLAY} state_t;
    state_t state_q, state_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
    logic [XLEN-1:0]      data_arr [NUM_LINES][LINE_WORDS];

    logic [OFF_W-1:0] count_q;
    logic             flush_pending_q;
    logic [XLEN-1:0]  replay_q;
    logic             fetch_valid_q;
    logic [XLEN-1:0]  fetch_data_q;
    logic             cache_miss_q;
    logic [XLEN-1:0]  miss_addr_q;

    logic [OFF_W-1:0] f_off, m_off;
    logic [IDX_W-1:0] f_idx, m_idx;
    logic [TAG_W-1:0] f_tag, m_tag;
    logic             hit, lookup_hit, lookup_miss, capture, last;
    logic [XLEN-1:0]  replay_word;
    logic             unused_addr_bits;

    assign f_off = bus.fetch_addr[OFF_W+1:2];
    assign f_idx = bus.fetch_addr[IDX_W+OFF_W+1:OFF_W+2];
    assign f_tag = bus.fetch_addr[XLEN-1:IDX_W+OFF_W+2];
    assign m_off = miss_addr_q[OFF_W+1:2];
    assign m_idx = miss_addr_q[IDX_W+OFF_W+1:OFF_W+2];
    assign m_tag = miss_addr_q[XLEN-1:IDX_W+OFF_W+2];
    assign unused_addr_bits = ^{bus.fetch_addr[1:0], miss_addr_q[1:0]};

    assign hit = valid_q[f_idx] && (tag_arr[f_idx] == f_tag);
    // The missed word may arrive in the very capture that ends the refill.
    assign replay_word = (count_q == m_off) ? bus.refill_data : replay_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        lookup_hit  = 1'b0;
        lookup_miss = 1'b0;
        capture     = 1'b0;
        last        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.fetch_req) begin
                    if (bus.flush || !hit) begin
                        lookup_miss = 1'b1;
                        state_d     = MISS;
                    end else begin
                        lookup_hit = 1'b1;
                    end
                end
            end
            MISS:   state_d = REFILL;
            REFILL: begin
                capture = bus.refill_valid || bus.refill_done;
                if (capture && (bus.refill_done || count_q == LAST_WORD)) begin
                    last    = 1'b1;
                    state_d = REPLAY;
                end
            end
            REPLAY:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q         <= '0;
            count_q         <= '0;
            flush_pending_q <= 1'b0;
            replay_q        <= '0;
            fetch_valid_q   <= 1'b0;
            fetch_data_q    <= '0;
            cache_miss_q    <= 1'b0;
            miss_addr_q     <= '0;
        end else begin
            fetch_valid_q <= lookup_hit || last;
            cache_miss_q  <= lookup_miss;
            if (lookup_hit)  fetch_data_q <= data_arr[f_idx][f_off];
            else if (last)   fetch_data_q <= replay_word;
            if (lookup_miss) miss_addr_q  <= bus.fetch_addr;

            if (capture) begin
                count_q <= count_q + 1'b1;
                if (count_q == m_off) replay_q <= bus.refill_data;
            end
            if (last) count_q <= '0;

            // A flush landing on the final capture still leaves the line invalid.
            if (bus.flush)
                valid_q <= '0;
            else if (last && !flush_pending_q)
                valid_q[m_idx] <= 1'b1;

            if (state_q == REPLAY)
                flush_pending_q <= 1'b0;
            else if (bus.flush && (state_q == MISS || state_q == REFILL))
                flush_pending_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) data_arr[m_idx][count_q] <= bus.refill_data;
        if (last)    tag_arr[m_idx]           <= m_tag;
    end

    assign bus.stall       = (state_q != IDLE);
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_data  = fetch_data_q;
    assign bus.cache_miss  = cache_miss_q;
    assign bus.miss_addr   = miss_addr_q;
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: hit tables, miss/refill sequences, flush and reset aborts.
module tb_icache;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    icache_if #(.XLEN(32)) bus ();
    icache #(.NUM_LINES(64), .LINE_WORDS(4), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        bit          hit;
        logic [31:0] data;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic prev_miss = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every fetch_valid must match the oldest expected word.
    always @(negedge clk) begin
        logic [31:0] e;
        if (bus.fetch_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_fetch_valid: got data %h expected no output at %0t",
                         bus.fetch_data, $time);
            end else begin
                e = exp_q.pop_front();
                if (bus.fetch_data !== e) begin
                    bad++;
                    $display("FAIL fetch_data: got %h expected %h at %0t", bus.fetch_data, e, $time);
                end
            end
        end
        if (bus.cache_miss === 1'b1) begin
            total++;
            if (prev_miss) begin
                bad++;
                $display("FAIL miss_twice: got cache_miss 1 expected 0 at %0t", $time);
            end
        end
        prev_miss = (bus.cache_miss === 1'b1);
    end

    task automatic run_vec(input vec_t v);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = v.addr;
        if (v.hit) exp_q.push_back(v.data);
        step();
        chk("hit_valid", {31'd0, bus.fetch_valid}, {31'd0, v.hit});
        chk("hit_no_miss", {31'd0, bus.cache_miss}, {31'd0, !v.hit});
        chk("hit_no_stall", {31'd0, bus.stall}, 32'd0);
        bus.fetch_req = 1'b0;
    endtask

    task automatic miss_refill(input logic [31:0] addr, input logic [31:0] base,
                               input int flush_at, input bit fl_req);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = addr;
        bus.flush      = fl_req;
        step();
        bus.fetch_req = 1'b0;
        bus.flush     = 1'b0;
        chk("miss_pulse", {31'd0, bus.cache_miss}, 32'd1);
        chk("miss_addr", bus.miss_addr, addr);
        chk("miss_stall", {31'd0, bus.stall}, 32'd1);
        chk("miss_no_valid", {31'd0, bus.fetch_valid}, 32'd0);
        step();
        chk("miss_drop", {31'd0, bus.cache_miss}, 32'd0);
        chk("refill_stall", {31'd0, bus.stall}, 32'd1);
        exp_q.push_back(base + {30'd0, addr[3:2]});
        for (int i = 0; i < 4; i++) begin
            bus.refill_valid = (i < 3);
            bus.refill_done  = (i == 3);
            bus.refill_data  = base + i;
            bus.flush        = (i == flush_at);
            step();
        end
        bus.refill_valid = 1'b0;
        bus.refill_done  = 1'b0;
        bus.flush        = 1'b0;
        chk("replay_valid", {31'd0, bus.fetch_valid}, 32'd1);
        chk("replay_stall", {31'd0, bus.stall}, 32'd1);
        step();
        chk("post_replay_stall", {31'd0, bus.stall}, 32'd0);
        chk("post_replay_valid", {31'd0, bus.fetch_valid}, 32'd0);
    endtask

    task automatic stray_refill(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.refill_valid = 1'b1;
            bus.refill_done  = (i == cycles - 1);
            bus.refill_data  = 32'hEEEE_0000 + i;
            step();
            chk("stray_no_valid", {31'd0, bus.fetch_valid}, 32'd0);
            chk("stray_no_stall", {31'd0, bus.stall}, 32'd0);
        end
        bus.refill_valid = 1'b0;
        bus.refill_done  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t_a[6];
        vec_t t_d[4];
        t_a[0] = '{32'h0000_0100, 1'b1, 32'hA0};
        t_a[1] = '{32'h0000_0104, 1'b1, 32'hA1};
        t_a[2] = '{32'h0000_0108, 1'b1, 32'hA2};
        t_a[3] = '{32'h0000_010C, 1'b1, 32'hA3};
        t_a[4] = '{32'h0000_0108, 1'b1, 32'hA2};
        t_a[5] = '{32'h0000_0100, 1'b1, 32'hA0};
        t_d[0] = '{32'h0000_0300, 1'b1, 32'hD0};
        t_d[1] = '{32'h0000_0304, 1'b1, 32'hD1};
        t_d[2] = '{32'h0000_0308, 1'b1, 32'hD2};
        t_d[3] = '{32'h0000_030C, 1'b1, 32'hD3};

        bus.fetch_req    = 1'b0;
        bus.fetch_addr   = '0;
        bus.flush        = 1'b0;
        bus.refill_valid = 1'b0;
        bus.refill_data  = '0;
        bus.refill_done  = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_valid", {31'd0, bus.fetch_valid}, 32'd0);
        chk("rst_miss", {31'd0, bus.cache_miss}, 32'd0);
        chk("rst_miss_addr", bus.miss_addr, 32'd0);
        chk("rst_data", bus.fetch_data, 32'd0);

        miss_refill(32'h0000_0104, 32'hA0, -1, 1'b0);
        for (int i = 0; i < 6; i++) run_vec(t_a[i]);

        miss_refill(32'h0000_0504, 32'hB0, -1, 1'b0);
        run_vec('{32'h0000_050C, 1'b1, 32'hB3});
        miss_refill(32'h0000_0104, 32'hA0, -1, 1'b0);
        run_vec('{32'h0000_0108, 1'b1, 32'hA2});

        miss_refill(32'h0000_0208, 32'hC0, 2, 1'b0);
        miss_refill(32'h0000_0208, 32'hC0, -1, 1'b0);
        run_vec('{32'h0000_0200, 1'b1, 32'hC0});

        // Reset mid-refill with the request held high while stalled.
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h0000_0300;
        step();
        chk("abort_miss", {31'd0, bus.cache_miss}, 32'd1);
        step();
        chk("held_req_no_miss", {31'd0, bus.cache_miss}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            bus.refill_valid = 1'b1;
            bus.refill_data  = 32'hE0 + i;
            step();
            chk("held_req_no_miss", {31'd0, bus.cache_miss}, 32'd0);
            chk("abort_stall", {31'd0, bus.stall}, 32'd1);
        end
        bus.fetch_req    = 1'b0;
        bus.refill_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_stall_clr", {31'd0, bus.stall}, 32'd0);
        chk("abort_valid_clr", {31'd0, bus.fetch_valid}, 32'd0);
        step();
        reset = 1'b0;

        stray_refill(2);
        miss_refill(32'h0000_0300, 32'hD0, -1, 1'b0);
        stray_refill(3);
        for (int i = 0; i < 4; i++) run_vec(t_d[i]);

        miss_refill(32'h0000_0304, 32'hD0, -1, 1'b1);
        miss_refill(32'h0000_0104, 32'hA0, -1, 1'b0);
        run_vec('{32'h0000_030C, 1'b1, 32'hD3});
        run_vec('{32'h0000_010C, 1'b1, 32'hA3});

        step();
        step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
